// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VGA timing side, CPU pixel writer, framebuffer RAM and DAC.
// oStallCount exists only when VRAM_ARB_STALL_CNT_EN is defined.
interface vram_arbiter_if #(
  parameter int XWidth = 8,
  parameter int YWidth = 8,
  parameter int DWidth = 8
);
  logic                      iDisplay;
  logic [XWidth-1:0]         iCol;
  logic [YWidth-1:0]         iRow;
  logic                      iWrReq;
  logic [XWidth+YWidth-1:0]  iWrAddr;
  logic [DWidth-1:0]         iWrData;
  logic                      oWrAck;
  logic                      oFifoFull;
  logic                      oFifoEmpty;
  logic [XWidth+YWidth-1:0]  oMemAddr;
  logic                      oMemWe;
  logic [DWidth-1:0]         oMemWrData;
  logic [DWidth-1:0]         iMemRdData;
  logic [DWidth-1:0]         oPixel;
  logic                      oPixelValid;
  logic [1:0]                oGrant;
`ifdef VRAM_ARB_STALL_CNT_EN
  logic [15:0]               oStallCount;
`endif

  modport slave (
    input  iDisplay, iCol, iRow, iWrReq, iWrAddr, iWrData, iMemRdData,
    output oWrAck, oFifoFull, oFifoEmpty, oMemAddr, oMemWe, oMemWrData,
           oPixel, oPixelValid, oGrant
`ifdef VRAM_ARB_STALL_CNT_EN
    , output oStallCount
`endif
  );

  modport master (
    output iDisplay, iCol, iRow, iWrReq, iWrAddr, iWrData, iMemRdData,
    input  oWrAck, oFifoFull, oFifoEmpty, oMemAddr, oMemWe, oMemWrData,
           oPixel, oPixelValid, oGrant
`ifdef VRAM_ARB_STALL_CNT_EN
    , input oStallCount
`endif
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetch owns the RAM while active, buffered CPU
// writes drain during blanking. Define VRAM_ARB_STALL_CNT_EN for the stall counter.
module vram_arbiter #(
  parameter int XWidth    = 8,
  parameter int YWidth    = 8,
  parameter int DWidth    = 8,
  parameter int FifoDepth = 4
) (
  input logic            Clock,
  input logic            Reset,
  vram_arbiter_if.slave  bus
);
  localparam int AWidth = XWidth + YWidth;
  localparam int PWidth = $clog2(FifoDepth);
  localparam int CWidth = PWidth + 1;
  localparam int Stages = 3;

  typedef struct packed {
    logic [AWidth-1:0] addr;
    logic [DWidth-1:0] data;
  } wrEntry_t;

  typedef enum logic [1:0] {
    GrNone = 2'd0,
    GrDisp = 2'd1,
    GrCpu  = 2'd2
  } grant_e;

  wrEntry_t          fifoMem [FifoDepth];
  wrEntry_t          head;
  logic [PWidth-1:0] wrPtr, rdPtr;
  logic [CWidth-1:0] count;
  logic              full, empty, push, pop;

  grant_e            grantQ, nextGrant;
  logic [AWidth-1:0] memAddr;
  logic [DWidth-1:0] memWrData;
  logic              memWe;
  logic              wrAck;

  logic [Stages:1]   vldPipe;
  logic [DWidth-1:0] pixel;

  assign full  = (count == CWidth'(FifoDepth));
  assign empty = (count == '0);
  assign head  = fifoMem[rdPtr];
  // Full is judged before the edge, so a same-edge pop never frees room for a push.
  assign push  = bus.iWrReq && !full;
  assign pop   = !bus.iDisplay && !empty;

  always_comb begin
    nextGrant = GrNone;
    if (bus.iDisplay) nextGrant = GrDisp;
    else if (!empty)  nextGrant = GrCpu;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      grantQ    <= GrNone;
      memAddr   <= '0;
      memWrData <= '0;
      memWe     <= 1'b0;
    end else begin
      grantQ <= nextGrant;
      memWe  <= 1'b0;
      case (nextGrant)
        GrDisp: memAddr <= {bus.iRow, bus.iCol};
        GrCpu: begin
          memAddr   <= head.addr;
          memWrData <= head.data;
          memWe     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (push) fifoMem[wrPtr] <= '{addr: bus.iWrAddr, data: bus.iWrData};
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      wrAck <= 1'b0;
    end else begin
      wrAck <= push;
      if (push) wrPtr <= wrPtr + PWidth'(1);
      if (pop)  rdPtr <= rdPtr + PWidth'(1);
      case ({push, pop})
        2'b10:   count <= count + CWidth'(1);
        2'b01:   count <= count - CWidth'(1);
        default: ;
      endcase
    end
  end

  // Fetch: addr out at N+1, RAM data at N+2, pixel registered at N+3.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      vldPipe <= '0;
      pixel   <= '0;
    end else begin
      vldPipe <= {vldPipe[Stages-1:1], bus.iDisplay};
      pixel   <= vldPipe[Stages-1] ? bus.iMemRdData : '0;
    end
  end

`ifdef VRAM_ARB_STALL_CNT_EN
  logic [15:0] stallCnt;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)                                        stallCnt <= '0;
    else if (bus.iWrReq && full && stallCnt != 16'hFFFF) stallCnt <= stallCnt + 16'd1;
  end

  assign bus.oStallCount = stallCnt;
`endif

  assign bus.oGrant      = grantQ;
  assign bus.oMemAddr    = memAddr;
  assign bus.oMemWrData  = memWrData;
  assign bus.oMemWe      = memWe;
  assign bus.oWrAck      = wrAck;
  assign bus.oFifoFull   = full;
  assign bus.oFifoEmpty  = empty;
  assign bus.oPixel      = pixel;
  assign bus.oPixelValid = vldPipe[Stages];
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous video RAM between the VGA pixel fetch path and a CPU-side pixel writer.
- Display fetch has absolute priority whenever the timing generator asserts its display-active flag.
- CPU writes are buffered in a small FIFO and drained to RAM only during blanking (horizontal or vertical).
- Sits between the VGA timing generator (col/row/display), the framebuffer RAM and the pixel output to the DAC.

Parameters:
- XWidth, 8, column index width.
- YWidth, 8, row index width.
- DWidth, 8, pixel data width.
- FifoDepth, 4, CPU write FIFO entries. Must be a power of 2, >= 2.

Ports:
- Clock  in  1  system/pixel clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- iDisplay  in  1  display-active flag from the timing generator.
- iCol  in  XWidth  current column, valid when iDisplay=1.
- iRow  in  YWidth  current row, valid when iDisplay=1.
- iWrReq  in  1  CPU write request.
- iWrAddr  in  XWidth+YWidth  CPU write address, ordered {row,col}.
- iWrData  in  DWidth  CPU write pixel.
- oWrAck  out  1  one-cycle pulse: a write was accepted on the previous edge.
- oFifoFull  out  1  FIFO holds FifoDepth entries.
- oFifoEmpty  out  1  FIFO holds 0 entries.
- oMemAddr  out  XWidth+YWidth  RAM address, registered.
- oMemWe  out  1  RAM write enable, registered.
- oMemWrData  out  DWidth  RAM write data, registered.
- iMemRdData  in  DWidth  RAM read data, valid 1 cycle after oMemAddr.
- oPixel  out  DWidth  pixel to the DAC; 0 when oPixelValid=0.
- oPixelValid  out  1  oPixel carries fetched data.
- oGrant  out  2  current RAM owner: 0=NONE, 1=DISP, 2=CPU.

Behaviour:
- Reset (Reset=0, asynchronous):
  - oGrant=NONE, oMemWe=0, oMemAddr=0, oMemWrData=0.
  - oPixel=0, oPixelValid=0, oWrAck=0.
  - FIFO pointers and count cleared, so oFifoEmpty=1 and oFifoFull=0. Pending writes are discarded.
  - Reset asserted mid-operation: the current RAM cycle is aborted (oMemWe drops immediately) and the display pipeline is flushed.
- Grant FSM, evaluated every cycle, next state chosen from current inputs:
  - iDisplay=1 -> DISP.
  - iDisplay=0 and FIFO non-empty -> CPU.
  - Otherwise -> NONE.
  - Any state can move to any state in one cycle. There is no hold or minimum grant time.
- DISP (registered outputs on the edge entering DISP at cycle N+1):
  - oMemAddr={iRow,iCol} sampled at cycle N; oMemWe=0.
- CPU:
  - The FIFO head is popped on the same edge.
  - oMemAddr/oMemWrData = head entry; oMemWe=1 for exactly one cycle per entry.
  - Back-to-back pops continue while blanking lasts and the FIFO is non-empty.
- NONE: oMemWe=0; oMemAddr holds its last value.
- Display pipeline (fixed latency 3):
  - Cycle N: iDisplay/iCol/iRow presented.
  - N+1: oMemAddr driven.
  - N+2: iMemRdData valid.
  - N+3: oPixel=iMemRdData, oPixelValid=1.
  - oPixelValid is iDisplay delayed exactly 3 cycles. When it is 0, oPixel=0.
- FIFO push:
  - Occurs on an edge where iWrReq=1 and oFifoFull=0 (flag value before the edge); oWrAck=1 the next cycle.
  - iWrReq=1 while full: no push, no ack. The CPU must hold the request.
- Simultaneous push and pop:
  - Allowed when not full; the count is unchanged.
  - When full, the push is refused even if a pop occurs on the same edge.
- Ordering: writes reach RAM in acceptance order.
- Pointers: wrap modulo FifoDepth. Count width is log2(FifoDepth)+1.
- The CPU never preempts display. A write that becomes eligible exactly as iDisplay rises waits until the next blanking period.

Optional Feature:
- Macro: VRAM_ARB_STALL_CNT_EN.
- Defined:
  - Adds output oStallCount [15:0].
  - Increments on every edge where iWrReq=1 and oFifoFull=1.
  - Saturates at 16'hFFFF; cleared by reset.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset, then iDisplay=1 with iCol=0..3, iRow=5 -> oMemAddr=0x0500..0x0503 on cycles 1..4; oPixelValid rises at cycle 3; oPixel equals RAM contents in order.
- During display, push 4 writes (addr 0x0102, data 0xAA, ...) -> 4 oWrAck pulses, oFifoFull=1, no oMemWe while iDisplay=1.
- Drop iDisplay with FIFO full -> oMemWe=1 on 4 consecutive cycles at the pushed addresses/data in order; oFifoEmpty=1 afterwards; oGrant 2 then 0.
- With FIFO full, hold iWrReq 3 cycles during display -> no ack, count stays 4; with VRAM_ARB_STALL_CNT_EN, oStallCount=3.
- FIFO at count 2 in blanking, simultaneous push and pop -> count stays 2, oWrAck=1, oMemWe=1.
- Assert Reset mid-drain with 3 entries -> oMemWe=0 immediately, oFifoEmpty=1, oPixelValid=0; after release, no stale writes appear.
